// File: rtl/fetch_queue.sv
// fetch_queue: FIFO between the fetch and decode stages.
// Ports: clk, rst (async, active-high); IF_PC/IF_Instruction/IF_Valid from
// fetch; Flush on taken branch; ID_Ready from decode; Freeze back to fetch;
// ID_Valid/ID_PC/ID_Instruction head entry to decode; Count occupancy.
module fetch_queue #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] IF_PC,
    input  logic [WORD_WIDTH-1:0] IF_Instruction,
    input  logic                  IF_Valid,
    input  logic                  Flush,
    input  logic                  ID_Ready,
    output logic                  Freeze,
    output logic                  ID_Valid,
    output logic [WORD_WIDTH-1:0] ID_PC,
    output logic [WORD_WIDTH-1:0] ID_Instruction,
    output logic [ADDR_W:0]       Count
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    logic [2*WORD_WIDTH-1:0] storage [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic [ADDR_W:0]         count;
    logic                    empty;
    logic                    push;
    logic                    pop;

    assign empty = (count == '0);

    // Freeze comes only from the registered count, so fetch never sees
    // a combinational path through the queue.  A full queue refuses to
    // push even when it pops in the same cycle (one bubble, by design).
    assign Freeze   = (count == FULL);
    assign push     = IF_Valid & ~Freeze & ~Flush;
    assign ID_Valid = ~empty & ~Flush;
    assign pop      = ID_Valid & ID_Ready;

    // Head is presented straight from storage; zero when empty so stale
    // entries never leak out after a flush or reset.
    assign {ID_PC, ID_Instruction} = empty ? '0 : storage[rd_ptr];
    assign Count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not cleared by Flush; the zeroed head output hides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (push) begin
            storage[wr_ptr] <= {IF_PC, IF_Instruction};
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Receiving end of the instruction-fetch interface.
- Sits between the fetch stage and the decode stage. Each cycle it accepts the fetch stage's {PC, instruction} pair into a small FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Drives Freeze back to the fetch stage when it cannot accept, so fetch holds its PC.
- Discards all buffered entries on a taken branch.

Parameters:
WORD_WIDTH, 32, width of PC and instruction words
DEPTH, 4, number of queue entries; must be a power of two, ≥2
ADDR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
IF_PC  input  WORD_WIDTH  PC value from fetch stage accompanying the instruction
IF_Instruction  input  WORD_WIDTH  instruction word from fetch stage
IF_Valid  input  1  fetch stage has a valid pair this cycle
Flush  input  1  branch taken; discard queue contents
ID_Ready  input  1  decode can consume the head entry this cycle
Freeze  output  1  to fetch stage: hold PC, pair not accepted
ID_Valid  output  1  head entry valid for decode
ID_PC  output  WORD_WIDTH  PC of head entry
ID_Instruction  output  WORD_WIDTH  instruction of head entry
Count  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, all storage=0. Outputs while in reset: Freeze=0, ID_Valid=0, ID_PC=0, ID_Instruction=0, Count=0.
- Reset mid-operation: all entries lost immediately; no output glitch back to old data after release.
- Freeze = (count == DEPTH). Derived from registered count only; no combinational path from any input.
- push = IF_Valid & ~Freeze & ~Flush.
  - Full with a simultaneous pop still does not push; this costs one bubble and is intentional.
- ID_Valid = (count != 0) & ~Flush.
- pop = ID_Valid & ID_Ready.
- ID_PC/ID_Instruction = storage[rd_ptr] when count != 0, else 0. Output is combinational from storage, so there is zero-cycle presentation of the head.
- Write path: on push, storage[wr_ptr] <= {IF_PC, IF_Instruction}; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read path: on pop, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
  - Count never exceeds DEPTH or underflows; pop is impossible when empty, push is impossible when full.
- Latency: a pair pushed at edge N is visible on ID_* after edge N (one cycle fetch→decode), same as a pipeline register when empty.
- Flush has priority over everything: at the next edge wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the flush cycle is suppressed.
  - Storage contents need not be cleared.
  - Freeze deasserts the cycle after flush.
- Flush while empty: no effect beyond pointer reset.
- Flush and rst together: reset wins.
- While Freeze=1, the fetch stage re-presents the same pair. The queue must not depend on IF_Valid staying stable; it simply does not sample.
- ID_Ready=0 with ID_Valid=1: the head is held stable (ID_PC/ID_Instruction unchanged) until popped or flushed.

Test Plan:
- Reset, then IF_Valid=1 with PCs 1,2,3,4,5 on consecutive cycles, ID_Ready=0 -> Count goes 1,2,3,4. Freeze=1 after the 4th edge; PC 5 is not stored; ID_PC=1 throughout.
- From full (PCs 1–4), ID_Ready=1, IF_Valid=1 with PC 5 held -> pop PC 1 (Count 3, Freeze=0). Next cycle push 5 and pop 2 together, Count stays 3. Pop order is 1,2,3,4,5 with no loss or duplication.
- Continuous stream of 10 pairs with ID_Ready=1 -> each PC appears on ID_PC exactly one cycle after it is offered. Pointers wrap past DEPTH and Count stays 1.
- Queue holds PCs 7,8,9; Flush=1 for one cycle with IF_Valid=1 (PC 20) and ID_Ready=1 -> ID_Valid=0 in that cycle. Next cycle Count=0, ID_PC=0, and PC 20 is not stored. A subsequent push of PC 40 appears as the head.
- Queue full; assert rst asynchronously mid-cycle -> Count=0, Freeze=0, ID_Valid=0 immediately. After release, the first push of PC 100 appears as ID_PC=100.
- Empty queue with ID_Ready=1 and IF_Valid=0 for 5 cycles -> ID_Valid=0, ID_PC=0, ID_Instruction=0, and Count stays 0 (no underflow).
